// File: rtl/stack_seq.sv
// Stack-operation sequencer: drives the SP block and byte-wide memory for
// 16-bit PUSH/POP and LD SP,HL, one byte per memory access.
module stack_seq #(
    parameter logic [1:0] OP_PUSH   = 2'd0,
    parameter logic [1:0] OP_POP    = 2'd1,
    parameter logic [1:0] OP_LDSPHL = 2'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] push_data,
    input  logic [15:0] sp,
    input  logic [7:0]  reg_file_out2,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  sp_sel,
    output logic [1:0]  temp_buf_sel,
    output logic        write_temp_buf,
    output logic        rf_byte_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [15:0] pop_data,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUSH_DEC = 3'd1;
    localparam logic [2:0] S_PUSH_HI  = 3'd2;
    localparam logic [2:0] S_PUSH_LO  = 3'd3;
    localparam logic [2:0] S_POP_LO   = 3'd4;
    localparam logic [2:0] S_POP_HI   = 3'd5;
    localparam logic [2:0] S_LD_LO    = 3'd6;
    localparam logic [2:0] S_LD_HI    = 3'd7;

    localparam logic [2:0] SP_HOLD = 3'd0;
    localparam logic [2:0] SP_INCR = 3'd1;
    localparam logic [2:0] SP_DECR = 3'd2;
    localparam logic [2:0] SP_TEMP = 3'd3;

    logic [2:0]  state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [15:0] pop_q, pop_d;
    logic        done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= 16'h0000;
            pop_q   <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pop_q   <= pop_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode from state_q so an asynchronous reset returns them to
    // their idle defaults immediately, without waiting for a clock edge.
    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        pop_d          = pop_q;
        done_d         = 1'b0;
        sp_sel         = SP_HOLD;
        temp_buf_sel   = 2'd0;
        write_temp_buf = 1'b0;
        rf_byte_sel    = 1'b0;
        mem_addr       = 16'h0000;
        mem_wdata      = 8'h00;
        mem_we         = 1'b0;
        mem_re         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_PUSH) begin
                        data_d  = push_data;
                        state_d = S_PUSH_DEC;
                    end else if (op == OP_POP) begin
                        data_d  = push_data;
                        state_d = S_POP_LO;
                    end else if (op == OP_LDSPHL) begin
                        data_d  = push_data;
                        state_d = S_LD_LO;
                    end
                end
            end
            S_PUSH_DEC: begin
                sp_sel  = SP_DECR;
                state_d = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = data_q[15:8];
                if (mem_ack) begin
                    sp_sel  = SP_DECR;
                    state_d = S_PUSH_LO;
                end
            end
            S_PUSH_LO: begin
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = data_q[7:0];
                if (mem_ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_POP_LO: begin
                mem_re   = 1'b1;
                mem_addr = sp;
                if (mem_ack) begin
                    pop_d[7:0] = mem_rdata;
                    sp_sel     = SP_INCR;
                    state_d    = S_POP_HI;
                end
            end
            S_POP_HI: begin
                mem_re   = 1'b1;
                mem_addr = sp;
                if (mem_ack) begin
                    pop_d[15:8] = mem_rdata;
                    sp_sel      = SP_INCR;
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                end
            end
            S_LD_LO: begin
                rf_byte_sel    = 1'b0;
                temp_buf_sel   = 2'd2;
                write_temp_buf = 1'b1;
                state_d        = S_LD_HI;
            end
            S_LD_HI: begin
                rf_byte_sel  = 1'b1;
                temp_buf_sel = 2'd2;
                sp_sel       = SP_TEMP;
                state_d      = S_IDLE;
                done_d       = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop_data = pop_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: an SP-block/memory environment with programmable wait
// states, a directed vector table, hand corner sequences and random ops.
`timescale 1ns/1ps
module tb_stack_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] push_data;
    logic [15:0] sp;
    logic [7:0]  reg_file_out2;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [2:0]  sp_sel;
    logic [1:0]  temp_buf_sel;
    logic        write_temp_buf;
    logic        rf_byte_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] pop_data;
    logic        busy;
    logic        done;

    stack_seq dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .push_data(push_data),
        .sp(sp), .reg_file_out2(reg_file_out2), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sp_sel(sp_sel), .temp_buf_sel(temp_buf_sel), .write_temp_buf(write_temp_buf),
        .rf_byte_sel(rf_byte_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .pop_data(pop_data), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // ---------------- environment: SP block, H/L bytes, memory ----------------
    logic [15:0] sp_reg;
    logic [7:0]  temp_lo;
    logic        sp_load = 1'b0;
    logic [15:0] sp_load_val = 16'h0000;
    logic [7:0]  h_val = 8'h00, l_val = 8'h00;
    int          wait_n = 0;
    int          cnt = 0;
    logic [7:0]  mem [0:65535];
    bit          written [0:65535];

    function automatic logic [7:0] fill(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign sp            = sp_reg;
    assign reg_file_out2 = rf_byte_sel ? h_val : l_val;
    assign mem_ack       = (mem_we || mem_re) && (cnt == wait_n);
    assign mem_rdata     = written[mem_addr] ? mem[mem_addr] : fill(mem_addr);

    always @(posedge clock) begin
        if (sp_load) sp_reg <= sp_load_val;
        else begin
            case (sp_sel)
                3'd1:    sp_reg <= sp_reg + 16'd1;
                3'd2:    sp_reg <= sp_reg - 16'd1;
                3'd3:    sp_reg <= {reg_file_out2, temp_lo};
                default: ;
            endcase
        end
        if (write_temp_buf) temp_lo <= (temp_buf_sel == 2'd2) ? reg_file_out2 : 8'h00;
        if (mem_we && mem_ack) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if ((mem_we || mem_re) && !mem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    // ---------------- reference model: a byte-addressed stack ----------------
    logic [15:0] ref_sp;
    logic [15:0] ref_pop = 16'h0000;
    logic [7:0]  ref_mem [logic [15:0]];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic model_op(input logic [1:0] o, input logic [15:0] d,
                            input logic [7:0] h, input logic [7:0] l);
        case (o)
            2'd0: begin
                ref_mem[ref_sp - 16'd1] = d[15:8];
                ref_mem[ref_sp - 16'd2] = d[7:0];
                ref_sp = ref_sp - 16'd2;
            end
            2'd1: begin
                ref_pop = {ref_rd(ref_sp + 16'd1), ref_rd(ref_sp)};
                ref_sp  = ref_sp + 16'd2;
            end
            2'd2: ref_sp = {h, l};
            default: ;
        endcase
    endtask

    function automatic int exp_latency(input logic [1:0] o, input int w);
        case (o)
            2'd0:    return 4 + 2 * w;
            2'd1:    return 3 + 2 * w;
            2'd2:    return 3;
            default: return 0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_sp(input logic [15:0] v);
        @(negedge clock);
        sp_load     = 1'b1;
        sp_load_val = v;
        @(negedge clock);
        sp_load = 1'b0;
        ref_sp  = v;
    endtask

    // Issues one op; lat = edges from the start edge (counted as 1) to done,
    // 0 if no done appears. ok flags protocol errors seen along the way.
    task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [7:0] h,
                          input logic [7:0] l, input int w, output int lat, output bit ok);
        bit          pv;
        logic [15:0] pa;
        logic [7:0]  pw;
        h_val = h; l_val = l; wait_n = w;
        @(negedge clock);
        start = 1'b1; op = o; push_data = d;
        lat = 0; ok = 1'b1; pv = 1'b0; pa = '0; pw = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (k == 1 && o != 2'd3) begin
                // Stray request while busy: must be ignored.
                start     = 1'b1;
                op        = 2'($urandom_range(0, 3));
                push_data = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (mem_we && mem_re) ok = 1'b0;
            if (pv && (mem_we || mem_re) && (mem_addr !== pa || mem_wdata !== pw)) ok = 1'b0;
            pv = (mem_we || mem_re) && !mem_ack;
            pa = mem_addr;
            pw = mem_wdata;
            if (o == 2'd3 && busy) ok = 1'b0;
            if (done) begin
                if (busy) ok = 1'b0;
                lat = k;
                break;
            end
            if (o == 2'd3 && k == 4) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        set;
        logic [15:0] sp0;
        logic [1:0]  op;
        logic [15:0] data;
        logic [7:0]  h;
        logic [7:0]  l;
        int          w;
        logic [15:0] exp_sp;
        logic [15:0] exp_pop;
        int          exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          lat;
        bit          ok;
        bit          seen;
        logic [1:0]  ro;
        logic [15:0] rd;
        logic [7:0]  rh, rl;
        int          rw;
        logic [15:0] a0, a1;

        tbl[0] = '{1'b1, 16'hFFFE, 2'd0, 16'h1234, 8'h00, 8'h00, 0, 16'hFFFC, 16'h0000, 4};
        tbl[1] = '{1'b0, 16'h0000, 2'd1, 16'h0000, 8'h00, 8'h00, 0, 16'hFFFE, 16'h1234, 3};
        tbl[2] = '{1'b0, 16'h0000, 2'd0, 16'hABCD, 8'h00, 8'h00, 2, 16'hFFFC, 16'h1234, 8};
        tbl[3] = '{1'b0, 16'h0000, 2'd1, 16'h0000, 8'h00, 8'h00, 1, 16'hFFFE, 16'hABCD, 5};
        tbl[4] = '{1'b0, 16'h0000, 2'd2, 16'h0000, 8'hC0, 8'hDE, 0, 16'hC0DE, 16'hABCD, 3};
        tbl[5] = '{1'b1, 16'h0001, 2'd0, 16'hBEEF, 8'h00, 8'h00, 0, 16'hFFFF, 16'hABCD, 4};
        tbl[6] = '{1'b0, 16'h0000, 2'd1, 16'h0000, 8'h00, 8'h00, 0, 16'h0001, 16'hBEEF, 3};
        tbl[7] = '{1'b0, 16'h0000, 2'd3, 16'h7777, 8'h00, 8'h00, 0, 16'h0001, 16'hBEEF, 0};

        reset = 1'b1; start = 1'b0; op = 2'd0; push_data = 16'h0000;
        ref_sp = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pop", 32'(pop_data), 32'd0);
        chk("rst_strobes", {24'd0, sp_sel, temp_buf_sel, write_temp_buf, rf_byte_sel, mem_we},
            32'd0);
        chk("rst_mem_out", {mem_re, 7'd0, mem_wdata, mem_addr}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].set) set_sp(tbl[i].sp0);
            run_op(tbl[i].op, tbl[i].data, tbl[i].h, tbl[i].l, tbl[i].w, lat, ok);
            model_op(tbl[i].op, tbl[i].data, tbl[i].h, tbl[i].l);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_sp", i), 32'(sp_reg), 32'(tbl[i].exp_sp));
            chk($sformatf("vec%0d_pop", i), 32'(pop_data), 32'(tbl[i].exp_pop));
            chk($sformatf("vec%0d_proto", i), 32'(ok), 32'd1);
            if (tbl[i].op == 2'd0) begin
                a0 = tbl[i].exp_sp;
                a1 = tbl[i].exp_sp + 16'd1;
                chk($sformatf("vec%0d_mem", i), {16'd0, mem[a1], mem[a0]}, 32'(tbl[i].data));
            end
            if (tbl[i].op != 2'd3) begin
                @(posedge clock);
                #1;
                chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            end
        end

        // Reset while the low byte of a push is waiting for its ack.
        set_sp(16'h8000);
        wait_n = 2;
        @(negedge clock);
        start = 1'b1; op = 2'd0; push_data = 16'h5AA5;
        @(posedge clock);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_we && sp_reg == 16'h7FFE) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk("rst_mid_reach_lo", 32'(seen), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) seen = 1'b1;
        end
        chk("rst_mid_no_done", 32'(seen), 32'd0);
        chk("rst_mid_pop", 32'(pop_data), 32'd0);
        ref_mem[16'h7FFF] = 8'h5A;
        ref_sp  = 16'h7FFE;
        ref_pop = 16'h0000;
        chk("rst_mid_sp", 32'(sp_reg), 32'(ref_sp));

        run_op(2'd0, 16'h0F0F, 8'h00, 8'h00, 0, lat, ok);
        model_op(2'd0, 16'h0F0F, 8'h00, 8'h00);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_sp", 32'(sp_reg), 32'(ref_sp));

        // Random ops against the reference stack.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) set_sp(16'($urandom));
            ro = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            rh = 8'($urandom);
            rl = 8'($urandom);
            rw = $urandom_range(0, 2);
            run_op(ro, rd, rh, rl, rw, lat, ok);
            model_op(ro, rd, rh, rl);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_latency(ro, rw)));
            chk($sformatf("rnd%0d_sp", i), 32'(sp_reg), 32'(ref_sp));
            chk($sformatf("rnd%0d_pop", i), 32'(pop_data), 32'(ref_pop));
            chk($sformatf("rnd%0d_proto", i), 32'(ok), 32'd1);
            if (ro == 2'd0) begin
                a0 = ref_sp;
                a1 = ref_sp + 16'd1;
                chk($sformatf("rnd%0d_mem", i), {16'd0, mem[a1], mem[a0]},
                    {16'd0, ref_rd(a1), ref_rd(a0)});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 Parameter OP_PUSH, default 2'd0, opcode for a 16-bit stack push.
REQ-002 Parameter OP_POP, default 2'd1, opcode for a 16-bit stack pop.
REQ-003 Parameter OP_LDSPHL, default 2'd2, opcode for SP <- HL.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a stack operation; sampled only when idle.
REQ-007 op  input  2  operation code; sampled with start.
REQ-008 push_data  input  16  word to push; sampled with start.
REQ-009 sp  input  16  current stack pointer from the SP register block.
REQ-010 reg_file_out2  input  8  register-file byte selected by rf_byte_sel.
REQ-011 mem_rdata  input  8  memory read data; valid in the mem_ack cycle.
REQ-012 mem_ack  input  1  memory completes the current access this cycle.
REQ-013 sp_sel  output  3  SP-block update select: 0 hold, 1 incr, 2 decr, 3 temp_buf.
REQ-014 temp_buf_sel  output  2  SP-block temp source: 0 data_bus, 2 reg_file_out2.
REQ-015 write_temp_buf  output  1  SP-block temp-buffer write strobe.
REQ-016 rf_byte_sel  output  1  register-file byte select: 0 L, 1 H.
REQ-017 mem_addr  output  16  memory address.
REQ-018 mem_wdata  output  8  memory write data.
REQ-019 mem_we  output  1  memory write request; held until mem_ack.
REQ-020 mem_re  output  1  memory read request; held until mem_ack.
REQ-021 pop_data  output  16  last popped word, registered.
REQ-022 busy  output  1  high while the state is not IDLE.
REQ-023 done  output  1  one-cycle registered completion pulse.

Function
REQ-024 States: IDLE, PUSH_DEC, PUSH_HI, PUSH_LO, POP_LO, POP_HI, LD_LO, LD_HI.
REQ-025 IDLE transition: with start=1, latch op and push_data, then go to PUSH_DEC, POP_LO or LD_LO by op.
REQ-026 IDLE with start=1 and op=2'd3 stays in IDLE with no done and no strobes.
REQ-027 While not IDLE, start, op and push_data are ignored.
REQ-028 PUSH_DEC: sp_sel=2 for exactly one cycle, then go to PUSH_HI.
REQ-029 PUSH_HI: mem_we=1, mem_addr=sp, mem_wdata=latched data[15:8].
REQ-030 PUSH_HI with mem_ack: sp_sel=2, then go to PUSH_LO.
REQ-031 PUSH_LO: mem_we=1, mem_addr=sp, mem_wdata=data[7:0].
REQ-032 PUSH_LO with mem_ack: sp_sel=0, then go to IDLE.
REQ-033 POP_LO: mem_re=1, mem_addr=sp; on mem_ack, pop_data[7:0] <= mem_rdata, sp_sel=1, then go to POP_HI.
REQ-034 POP_HI: mem_re=1, mem_addr=sp; on mem_ack, pop_data[15:8] <= mem_rdata, sp_sel=1, then go to IDLE.
REQ-035 LD_LO: rf_byte_sel=0, temp_buf_sel=2, write_temp_buf=1, then go to LD_HI.
REQ-036 LD_HI: rf_byte_sel=1, temp_buf_sel=2, sp_sel=3, then go to IDLE.
REQ-037 A memory state without mem_ack holds its state and drives sp_sel=0, with mem_addr and mem_wdata stable (wait states unbounded).
REQ-038 done=1 in the cycle after the final-state transition to IDLE; busy=0 in that cycle.
REQ-039 start asserted in the done cycle is accepted.
REQ-040 Default outputs in IDLE and wherever not specified above: sp_sel=0, temp_buf_sel=0, write_temp_buf=0, rf_byte_sel=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-041 mem_we and mem_re are never high together.
REQ-042 Addresses wrap modulo 2^16 through the SP block; the sequencer applies no saturation.
REQ-043 Latency with mem_ack tied high: PUSH 3 cycles, POP 2 cycles, LD SP,HL 2 cycles from the start edge to return to IDLE; done follows one cycle later.

Reset
REQ-044 reset=1 immediately forces IDLE, clears done, pop_data and the latched op/data, and drives all outputs to their REQ-040 defaults, including mid-operation.
REQ-045 After reset deasserts, the first start is accepted normally.

Verification
REQ-046 sp=FFFE, PUSH 0x1234, mem_ack=1 -> writes 0x12 to FFFD, then 0x34 to FFFC; final sp=FFFC; done 4 cycles after start.
REQ-047 sp=FFFC, memory FFFC=0x34 and FFFD=0x12, POP -> pop_data=0x1234; sp=FFFE; done 3 cycles after start.
REQ-048 PUSH with 2 wait cycles per access -> addr/wdata stable; sp changes only on ack edges; done 8 cycles after start.
REQ-049 H=0xC0, L=0xDE, LD SP,HL -> write_temp_buf then sp_sel=3 with rf_byte_sel 0 then 1; sp=C0DE.
REQ-050 Start pulsed during busy, and op=3 from IDLE -> both ignored; reset during PUSH_LO -> mem_we drops asynchronously, busy=0, no done.
